// File: rtl/stepgen_q.sv
// stepgen_q: velocity phase accumulator -> bounded signed pending-step counter -> timed step/dir sequencer.
// Define STEPGEN_Q_QUAD_EN to add the quadrature output mode selected by the mode input.
module stepgen_q #(
  parameter int W = 16,
  parameter int F = 10,
  parameter int T = 5,
  parameter int P = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic signed [F:0]    velocity,
  input  logic        [T-1:0]  dirtime,
  input  logic        [T-1:0]  steptime,
  input  logic                 mode,
  output logic        [W+F-1:0] position,
  output logic        [W-1:0]  out_pos,
  output logic                 step,
  output logic                 dir,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIRSETUP,
    S_HIGH,
    S_LOW,
    S_DWELL
  } state_e;

  localparam logic signed [P:0] PendOne = (P+1)'(1);
  localparam logic signed [P:0] PendMax = (P+1)'(2**(P-1) - 1);
  localparam logic signed [P:0] PendMin = -PendMax;

  logic [W+F-1:0]        pos_q, pos_d;
  logic                  xing_q, xing_d;
  logic                  xdir_q, xdir_d;
  logic signed [P-1:0]   pend_q, pend_d;
  logic signed [P:0]     pend_sum;
  logic                  err_q, err_d;
  state_e                state_q, state_d;
  logic [T-1:0]          timer_q, timer_d;
  logic                  step_q, step_d;
  logic                  dir_q, dir_d;
  logic [W-1:0]          opos_q, opos_d;

  logic pend_nz, want_dir, tmr_zero, decide, consume;

`ifndef STEPGEN_Q_QUAD_EN
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign pend_nz  = (pend_q != '0);
  assign want_dir = ~pend_q[P-1];
  assign tmr_zero = (timer_q == '0);
  // DIRSETUP expiry re-runs the IDLE decision, so a step can launch on that same edge.
  assign decide   = (state_q == S_IDLE) || ((state_q == S_DIRSETUP) && tmr_zero);

  // Accumulator and crossing detect; the crossing is registered so pending lags position by one clk.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pos_d  = pos_q;
    if (enable) pos_d = pos_q + {{(W-1){velocity[F]}}, velocity};
    xing_d = pos_d[F] ^ pos_q[F];
    xdir_d = ~velocity[F];
  end

  // Pending counter: net of registered crossing and sequencer consumption, saturating.
  always_comb begin
    err_d    = err_q;
    pend_sum = {pend_q[P-1], pend_q};
    if (xing_q) pend_sum = xdir_q ? pend_sum + PendOne : pend_sum - PendOne;
    if (consume) pend_sum = want_dir ? pend_sum - PendOne : pend_sum + PendOne;
    if (pend_sum > PendMax) begin
      pend_d = PendMax[P-1:0];
      err_d  = 1'b1;
    end else if (pend_sum < PendMin) begin
      pend_d = PendMin[P-1:0];
      err_d  = 1'b1;
    end else begin
      pend_d = pend_sum[P-1:0];
    end
  end

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_q   <= '0;
      xing_q  <= 1'b0;
      xdir_q  <= 1'b0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      state_q <= S_IDLE;
      timer_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      opos_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      pos_q   <= pos_d;
      xing_q  <= xing_d;
      xdir_q  <= xdir_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      state_q <= state_d;
      timer_q <= timer_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      opos_q  <= opos_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HIGH:  if (tmr_zero) state_d = S_LOW;
      S_LOW:   if (tmr_zero) state_d = S_IDLE;
      S_DWELL: if (tmr_zero) state_d = S_IDLE;
      default: ;
    endcase
    if (decide) begin
      state_d = S_IDLE;
      if (pend_nz) begin
`ifdef STEPGEN_Q_QUAD_EN
        if (mode) state_d = S_DWELL;
        else
`endif
        if (want_dir != dir_q) state_d = S_DIRSETUP;
        else                   state_d = S_HIGH;
      end
    end
  end

  // Output / datapath logic for the sequencer.
  always_comb begin
    step_d  = step_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    consume = 1'b0;
    unique case (state_q)
      S_HIGH: begin
        if (tmr_zero) begin
          step_d  = 1'b0;
          timer_d = steptime;
        end else begin
          timer_d = timer_q - T'(1);
        end
      end
      S_DIRSETUP, S_LOW, S_DWELL: if (!tmr_zero) timer_d = timer_q - T'(1);
      default: ;
    endcase
    if (decide && pend_nz) begin
`ifdef STEPGEN_Q_QUAD_EN
      if (mode) begin
        // Gray walk on {A,B}: forward 00->10->11->01, reverse the other way.
        {step_d, dir_d} = want_dir ? {~dir_q, step_q} : {dir_q, ~step_q};
        timer_d = steptime;
        consume = 1'b1;
      end else
`endif
      if (want_dir != dir_q) begin
        dir_d   = want_dir;
        timer_d = dirtime;
      end else begin
        step_d  = 1'b1;
        timer_d = steptime;
        consume = 1'b1;
      end
    end
    opos_d = opos_q;
    if (consume) opos_d = want_dir ? opos_q + W'(1) : opos_q - W'(1);
  end

  assign position = pos_q;
  assign out_pos  = opos_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE) || pend_nz;

endmodule

// File: doc/stepgen_q.md
Name: stepgen_q

Overview:
- Single-channel step generator for the step/dir firmware; successor to the current fixed-width stepgen.
- A velocity-driven phase accumulator produces commanded steps into a bounded signed pending-step counter.
- An output sequencer drains that counter with programmable dir-setup and step high/low times.
- Adds an emitted-position counter, an overflow flag, and an optional quadrature output mode.

Parameters:
W, 16, integer bits of accumulator position
F, 10, fractional bits; velocity is F+1 bits signed
T, 5, width of timing inputs/timer
P, 4, width of signed pending-step counter

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
enable  in  1  1 = accumulator integrates velocity
velocity  in  F+1  signed velocity, two's complement, fraction of a step per clk
dirtime  in  T  dir setup cycles minus 1
steptime  in  T  step high / step low cycles minus 1
mode  in  1  0 = step/dir, 1 = quadrature (STEPGEN_Q_QUAD_EN only)
position  out  W+F  accumulator value
out_pos  out  W  signed count of steps actually emitted
step  out  1  step pulse / quadrature phase A
dir  out  1  direction / quadrature phase B
busy  out  1  sequencer not IDLE or pending != 0
err  out  1  sticky pending-counter overflow

Behaviour:
- Reset (reset_n low at clk edge): position=0, pending=0, out_pos=0, step=0, dir=0, err=0, timer=0, state=IDLE, busy=0. Reset mid-pulse truncates the pulse immediately. No output glitch beyond the clk edge.
- Accumulator:
  - enable=1: position <= position + sign_extend(velocity), wrapping modulo 2^(W+F).
  - enable=0: position holds; the sequencer keeps draining pending.
  - |velocity| < 2^F, so the integer part changes by at most ±1 per clk.
- Crossing detect: compare bit F of the old and new position registers. A change is a crossing; its sign is the sign of velocity. pending is updated one clk after the position update. velocity = -2^F is illegal; no behaviour is guaranteed for it.
- Pending:
  - Signed P-bit counter, range ±(2^(P-1)-1).
  - Crossing and sequencer consume in the same clk: net update.
  - An increment beyond the range saturates and sets err. err clears only on reset.
- Sequencer, step/dir mode:
  - IDLE: if pending != 0, let d = (pending > 0).
    - If d != dir: dir <= d, timer <= dirtime, go DIRSETUP.
    - Otherwise: step <= 1, timer <= steptime, consume one pending toward zero, out_pos ±= 1, go HIGH.
  - DIRSETUP: count timer to 0, then behave as IDLE with a matching dir.
  - HIGH: when timer=0, step <= 0, timer <= steptime, go LOW.
  - LOW: when timer=0, go IDLE.
  - Each timed state lasts value+1 clks.
  - dir never changes while step=1 or during LOW.
- Latency: a crossing registered at edge k gives pending at edge k+1 and step=1 after edge k+2, when no dir change is needed.
- Max sustained rate with dirtime=steptime=0: one step per 3 clks (HIGH, LOW, IDLE). Faster command rates accumulate in pending.
- out_pos wraps modulo 2^W.
- busy is combinational from state and pending.

Optional Feature:
STEPGEN_Q_QUAD_EN.
- Defined, mode=1:
  - step/dir carry a Gray sequence {A,B}: 00→10→11→01→00 for positive, reverse for negative.
  - Each consumed step advances one Gray state, then waits steptime+1 clks in DWELL before returning to IDLE.
  - No DIRSETUP state; dirtime is ignored.
  - Switching mode while busy=1 is undefined; change it only while busy=0.
- Not defined: mode input ignored, quadrature logic absent, step/dir mode only.

Test Plan:
- Reset: drive velocity=+300 with enable=1 for 50 clks, then reset_n=0 for 1 clk → position=0, out_pos=0, step=0, dir=0, err=0, busy=0.
- Velocity +256 (F=10, 0.25 step/clk), dirtime=0, steptime=0, 400 clks → 100 step pulses each 1 clk high, dir=1, out_pos=100, err=0.
- Reversal: +256 for 40 clks, then -256, dirtime=5 → after the last positive step's LOW, dir falls and 6 clks elapse before the next rising step; out_pos returns toward 0.
- Overflow: velocity +512, steptime=3 (8+ clks/step vs 2 clks/crossing) → pending saturates at 7, err=1 and stays 1 after velocity=0; all pending drain; busy falls.
- enable=0 mid-run with pending=3 → position frozen; exactly 3 further pulses; busy then 0.
- STEPGEN_Q_QUAD_EN, mode=1, velocity +256, steptime=1 → {step,dir} cycles 00,10,11,01; negative velocity reverses the order; out_pos counts match.
